// File: rtl/sig_bounce_generator.sv
`timescale 1ns/1ps
// sig_bounce_generator
//   Contact-bounce emulator. When sig_clean moves away from sig_bouncy, the
//   output toggles immediately. It then emits N glitch pairs, each level held
//   for a drawn number of cycles, and holds the final level for SETTLE_CYCLES
//   before the next request is accepted. Total toggles per transition are
//   2N+1, so the output always ends at the requested level.
//
//   Build option BOUNCE_FIXED_EN: when defined, N = MAX_BOUNCES and every
//   hold = MAX_PULSE, and no LFSR is built. When undefined, N and the holds
//   come from a free-running 16-bit Galois LFSR (mask 16'hB400).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   ena          clock enable; 0 freezes every register, LFSR included
//   sig_clean    requested level, assumed synchronous to clk
//   sig_bouncy   emulated bouncing output
//   busy         high while a sequence is bouncing or settling
//   bounce_count N drawn for the current or last transition
//   settled      one-cycle pulse when a sequence completes
module sig_bounce_generator #(
    parameter int          MAX_BOUNCES   = 6,
    parameter int          MIN_PULSE     = 1,
    parameter int          MAX_PULSE     = 8,
    parameter int          SETTLE_CYCLES = 5,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ena,
    input  logic                               sig_clean,
    output logic                               sig_bouncy,
    output logic                               busy,
    output logic [$clog2(MAX_BOUNCES+1):0]     bounce_count,
    output logic                               settled
);

    localparam int CW = $clog2(MAX_BOUNCES + 1) + 1;  // bounce_count width
    localparam int EW = CW + 1;                        // holds 2*N
    localparam int HW = $clog2(MAX_PULSE + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t          state,      state_nxt;
    logic            bouncy_nxt;
    logic [CW-1:0]   count_nxt;
    logic [EW-1:0]   edges_left, edges_nxt;
    logic [HW-1:0]   hold_cnt,   hold_nxt;
    logic [SW-1:0]   settle_cnt, settle_nxt;
    logic            settled_nxt;

    logic [CW-1:0]   draw_n;
    logic [HW-1:0]   draw_hold;

`ifdef BOUNCE_FIXED_EN
    assign draw_n    = CW'(MAX_BOUNCES);
    assign draw_hold = HW'(MAX_PULSE);
`else
    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr;

    // Both draws read the current LFSR value; the hold uses bits above the
    // low nibble so it is less correlated with N.
    assign draw_n    = CW'(32'(lfsr) % (MAX_BOUNCES + 1));
    assign draw_hold = HW'(MIN_PULSE + (32'(lfsr) >> 4) % (MAX_PULSE - MIN_PULSE + 1));

    // The LFSR runs on every enabled edge whatever the state, so the draws
    // depend on when a transition arrives as well as on the seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED_EFF;
        end else if (ena) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`endif

    assign busy = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt   = state;
        bouncy_nxt  = sig_bouncy;
        count_nxt   = bounce_count;
        edges_nxt   = edges_left;
        hold_nxt    = hold_cnt;
        settle_nxt  = settle_cnt;
        settled_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (sig_clean != sig_bouncy) begin
                    // First edge of the burst leaves with zero latency.
                    bouncy_nxt = ~sig_bouncy;
                    count_nxt  = draw_n;
                    edges_nxt  = {draw_n, 1'b0};
                    hold_nxt   = draw_hold;
                    if (draw_n == '0) begin
                        state_nxt  = SETTLE;
                        settle_nxt = SW'(SETTLE_CYCLES);
                    end else begin
                        state_nxt = BOUNCE;
                    end
                end
            end

            BOUNCE: begin
                // The level was held for the full drawn width once hold is 1.
                if (hold_cnt <= HW'(1)) begin
                    bouncy_nxt = ~sig_bouncy;
                    edges_nxt  = edges_left - 1'b1;
                    hold_nxt   = draw_hold;
                    if (edges_left == EW'(1)) begin
                        state_nxt  = SETTLE;
                        settle_nxt = SW'(SETTLE_CYCLES);
                    end
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end

            SETTLE: begin
                if (settle_cnt <= SW'(1)) begin
                    settled_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    settle_nxt = settle_cnt - 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge values, independent of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            sig_bouncy   <= 1'b0;
            bounce_count <= '0;
            edges_left   <= '0;
            hold_cnt     <= '0;
            settle_cnt   <= '0;
            settled      <= 1'b0;
        end else if (ena) begin
            state        <= state_nxt;
            sig_bouncy   <= bouncy_nxt;
            bounce_count <= count_nxt;
            edges_left   <= edges_nxt;
            hold_cnt     <= hold_nxt;
            settle_cnt   <= settle_nxt;
            settled      <= settled_nxt;
        end
    end

endmodule
